// File: rtl/ber_test_ctrl.sv
// BER test sequencer: clears the BER counters, waits for I/Q phase lock, then measures a window of symbols.
// Results and status latch on entry to REPORT, so they are valid during the one-cycle o_done pulse.
`timescale 1ns/1ps
module ber_test_ctrl #(
   parameter int CLR_CYC = 4,
   parameter int WIN_W   = 32,
   parameter int TO_W    = 24,
   parameter int CNT_W   = 64
) (
   input  logic             clock,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_valid,
   input  logic             i_lock_i,
   input  logic             i_lock_q,
   input  logic             i_err_i,
   input  logic             i_err_q,
   input  logic [WIN_W-1:0] i_window,
   input  logic [TO_W-1:0]  i_timeout,
   output logic             o_ber_reset,
   output logic             o_ber_enable,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_status,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic [CNT_W-1:0] o_err_cnt_i,
   output logic [CNT_W-1:0] o_err_cnt_q
);

   localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
   localparam int CMP_W = (CNT_W > WIN_W) ? CNT_W : WIN_W;
   localparam logic [1:0] ST_PASS = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;
   localparam logic [1:0] ST_LOST = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEARCH, S_MEASURE, S_REPORT} state_t;

   state_t           state_q, state_d;
   logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] erri_cnt_q, erri_cnt_d;
   logic [CNT_W-1:0] errq_cnt_q, errq_cnt_d;
   logic [1:0]       status_q, status_d;
   logic [CNT_W-1:0] res_bit_q, res_bit_d;
   logic [CNT_W-1:0] res_erri_q, res_erri_d;
   logic [CNT_W-1:0] res_errq_q, res_errq_d;
   logic [1:0]       rep_status;
   logic [TO_W-1:0]  to_inc;
   logic             locked;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      state_d    = state_q;
      clr_cnt_d  = clr_cnt_q;
      win_d      = win_q;
      to_d       = to_q;
      to_cnt_d   = to_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      erri_cnt_d = erri_cnt_q;
      errq_cnt_d = errq_cnt_q;
      status_d   = status_q;
      res_bit_d  = res_bit_q;
      res_erri_d = res_erri_q;
      res_errq_d = res_errq_q;
      rep_status = status_q;
      to_inc     = to_cnt_q;
      locked     = i_lock_i && i_lock_q;

      case (state_q)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               state_d    = S_CLEAR;
               win_d      = i_window;
               to_d       = i_timeout;
               clr_cnt_d  = '0;
               to_cnt_d   = '0;
               bit_cnt_d  = '0;
               erri_cnt_d = '0;
               errq_cnt_d = '0;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) state_d = S_SEARCH;
            else clr_cnt_d = clr_cnt_q + CLR_W'(1);
         end
         S_SEARCH: begin
            if (i_valid && (to_cnt_q != '1)) to_inc = to_cnt_q + TO_W'(1);
            to_cnt_d = to_inc;
            // Lock wins even when this cycle's symbol also reaches the timeout.
            if (locked) begin
               state_d = S_MEASURE;
            end else if (to_inc >= to_q) begin
               state_d    = S_REPORT;
               rep_status = ST_TMO;
            end
         end
         S_MEASURE: begin
            if (!locked) begin
               state_d    = S_REPORT;
               rep_status = ST_LOST;
            end else if (win_q == '0) begin
               state_d    = S_REPORT;
               rep_status = ST_PASS;
            end else if (i_valid) begin
               bit_cnt_d  = sat_inc(bit_cnt_q);
               erri_cnt_d = i_err_i ? sat_inc(erri_cnt_q) : erri_cnt_q;
               errq_cnt_d = i_err_q ? sat_inc(errq_cnt_q) : errq_cnt_q;
               // A saturated bit counter below the window never matches, by design.
               if (CMP_W'(bit_cnt_d) == CMP_W'(win_q)) begin
                  state_d    = S_REPORT;
                  rep_status = ST_PASS;
               end
            end
         end
         S_REPORT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (i_abort && (state_q == S_CLEAR || state_q == S_SEARCH || state_q == S_MEASURE))
         state_d = S_IDLE;

      if (state_d == S_REPORT) begin
         status_d   = rep_status;
         res_bit_d  = bit_cnt_d;
         res_erri_d = erri_cnt_d;
         res_errq_d = errq_cnt_d;
      end
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= S_IDLE;
         clr_cnt_q  <= '0;
         win_q      <= '0;
         to_q       <= '0;
         to_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         erri_cnt_q <= '0;
         errq_cnt_q <= '0;
         status_q   <= '0;
         res_bit_q  <= '0;
         res_erri_q <= '0;
         res_errq_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         win_q      <= win_d;
         to_q       <= to_d;
         to_cnt_q   <= to_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         erri_cnt_q <= erri_cnt_d;
         errq_cnt_q <= errq_cnt_d;
         status_q   <= status_d;
         res_bit_q  <= res_bit_d;
         res_erri_q <= res_erri_d;
         res_errq_q <= res_errq_d;
      end
   end

   assign o_ber_reset  = (state_q == S_CLEAR);
   assign o_ber_enable = (state_q == S_SEARCH) || (state_q == S_MEASURE);
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = (state_q == S_REPORT);
   assign o_status     = status_q;
   assign o_bit_cnt    = res_bit_q;
   assign o_err_cnt_i  = res_erri_q;
   assign o_err_cnt_q  = res_errq_q;

endmodule
